// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, ignore list and decode FSM encoding shared by the PS/2 receiver.
package ps2_pkg;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam logic [7:0] PS2_BAT   = 8'hAA;
   localparam logic [7:0] PS2_ACK   = 8'hFA;
   localparam logic [7:0] PS2_ECHO  = 8'hEE;
   localparam logic [7:0] PS2_RSND  = 8'hFE;
   localparam logic [7:0] PS2_ERR0  = 8'h00;
   localparam logic [7:0] PS2_ERR1  = 8'hFF;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   function automatic logic is_ignored(input logic [7:0] b);
      return b inside {PS2_PAUSE, PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RSND, PS2_ERR0, PS2_ERR1};
   endfunction
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes and filters the PS/2 lines and assembles 11-bit frames into bytes.
module ps2_rx_frame #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 12500
) (
   input  logic       iCLK,
   input  logic       iRST_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]    clk_s, dat_s;
   logic          filt, tick, parity;
   logic [FW-1:0] fcnt;
   logic [TW-1:0] tcnt;
   logic [3:0]    idx;
   logic          flip;
   assign flip = (clk_s[1] != filt) && (fcnt == FW'(FILTER_LEN - 1));
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         clk_s <= 2'b11;
         dat_s <= 2'b11;
         filt  <= 1'b1;
         fcnt  <= '0;
         tick  <= 1'b0;
      end else begin
         clk_s <= {clk_s[0], ps2_clk};
         dat_s <= {dat_s[0], ps2_data};
         fcnt  <= (clk_s[1] == filt || flip) ? '0 : fcnt + 1'b1;
         filt  <= flip ? clk_s[1] : filt;
         tick  <= flip && filt;
      end
   // Timeout only runs inside a frame, so an idle bus never raises frame_err.
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         idx        <= '0;
         rx_byte    <= '0;
         parity     <= 1'b0;
         tcnt       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (tick) begin
            tcnt <= '0;
            if (idx == 4'd0) idx <= dat_s[1] ? 4'd0 : 4'd1;
            else if (idx <= 4'd8) begin
               rx_byte <= {dat_s[1], rx_byte[7:1]};
               idx     <= idx + 4'd1;
            end else if (idx == 4'd9) begin
               parity <= dat_s[1];
               idx    <= 4'd10;
            end else begin
               idx        <= '0;
               byte_valid <= dat_s[1] && (^rx_byte ^ parity);
               frame_err  <= !(dat_s[1] && (^rx_byte ^ parity));
            end
         end else if (idx == 4'd0) tcnt <= '0;
         else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tcnt      <= '0;
            idx       <= '0;
            frame_err <= 1'b1;
         end else tcnt <= tcnt + 1'b1;
      end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: strips E0/F0 prefixes from received scan codes and strobes each make code.
module ps2_key_decoder import ps2_pkg::*; #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 12500
) (
   input  logic       iCLK,
   input  logic       iRST_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_in,
   output logic       key_en,
   output logic       key_ext,
   output logic       frame_err
);
   logic [7:0] rx_byte;
   logic       byte_valid, make;
   state_t     state, state_nx;
   ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .iCLK(iCLK), .iRST_n(iRST_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_byte(rx_byte), .byte_valid(byte_valid), .frame_err(frame_err)
   );
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) state <= IDLE;
      else state <= state_nx;
   // A break prefix swallows exactly one following byte, whichever state it came from.
   always_comb begin
      state_nx = state;
      make     = 1'b0;
      if (frame_err) state_nx = IDLE;
      else if (byte_valid)
         case (state)
            IDLE: begin
               state_nx = rx_byte == PS2_EXT ? EXT : rx_byte == PS2_BRK ? BRK : IDLE;
               make     = !(rx_byte inside {PS2_EXT, PS2_BRK}) && !is_ignored(rx_byte);
            end
            EXT: begin
               state_nx = rx_byte == PS2_BRK ? EXT_BRK : rx_byte == PS2_EXT ? EXT : IDLE;
               make     = !(rx_byte inside {PS2_EXT, PS2_BRK});
            end
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         key_in  <= '0;
         key_ext <= 1'b0;
         key_en  <= 1'b0;
      end else begin
         key_en <= make;
         if (make) begin
            key_in  <= rx_byte;
            key_ext <= state == EXT;
         end
      end
endmodule
